// File: rtl/pipe_ctrl_if.sv
// Pipeline control bus between the stage chain and pipe_ctrl.
//   Hazard/branch/memory-response signals flow toward pipe_ctrl; per-stage
//   stall/clear vectors and fault/busy status flow back to the stages.
//   master : stage chain side (drives i_*, observes o_*)
//   slave  : pipe_ctrl side (observes i_*, drives o_*)
//   Memory response codes: OK = 0, WAIT = 1, ERR = 2 (3 is treated as ERR).
`ifndef PIPE_CTRL_MEM_CODES
`define PIPE_CTRL_MEM_CODES
`define MEM_CODE_W    2
`define MEM_CODE_OK   2'd0
`define MEM_CODE_WAIT 2'd1
`define MEM_CODE_ERR  2'd2
`endif

interface pipe_ctrl_if #(
  parameter int unsigned NUM_STAGES = 5
);
  logic                   i_mem_hazard;
  logic                   i_branch;
  logic                   i_mem_req_en;
  logic [`MEM_CODE_W-1:0] i_mem_res_code;
  logic [NUM_STAGES-1:0]  o_stall;
  logic [NUM_STAGES-1:0]  o_clr;
  logic                   o_fault;
  logic [1:0]             o_fault_code;
  logic                   o_busy;

  modport master (
    output i_mem_hazard, i_branch, i_mem_req_en, i_mem_res_code,
    input  o_stall, o_clr, o_fault, o_fault_code, o_busy
  );

  modport slave (
    input  i_mem_hazard, i_branch, i_mem_req_en, i_mem_res_code,
    output o_stall, o_clr, o_fault, o_fault_code, o_busy
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Central stall/flush controller for the N-stage core.
//   Drives per-stage stall and clear vectors from load-use hazards, taken
//   branches and variable-latency memory responses; sequences the pipeline
//   out of reset and latches memory faults. Bit 0 is FE, bit NUM_STAGES-1 WB.
// Ports:
//   clk  : clock
//   clr  : synchronous reset, active-high
//   bus  : pipe_ctrl_if.slave (hazard/branch/mem inputs, stall/clr/fault/busy outputs)
`ifndef PIPE_CTRL_MEM_CODES
`define PIPE_CTRL_MEM_CODES
`define MEM_CODE_W    2
`define MEM_CODE_OK   2'd0
`define MEM_CODE_WAIT 2'd1
`define MEM_CODE_ERR  2'd2
`endif

module pipe_ctrl #(
  parameter int unsigned NUM_STAGES   = 5,
  parameter int unsigned ID_STAGE     = 1,
  parameter int unsigned BR_STAGE     = 2,
  parameter int unsigned MEM_STAGE    = 3,
  parameter int unsigned RESET_CYCLES = 4,
  parameter int unsigned MEM_TIMEOUT  = 255
) (
  input logic       clk,
  input logic       clr,
  pipe_ctrl_if.slave bus
);

  // Bits [n-1:0] set.
  function automatic logic [NUM_STAGES-1:0] low_mask(input int unsigned n);
    logic [NUM_STAGES-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [NUM_STAGES-1:0] ID_STALL  = low_mask(ID_STAGE + 1);
  localparam logic [NUM_STAGES-1:0] ID_BUB    = NUM_STAGES'(1) << (ID_STAGE + 1);
  localparam logic [NUM_STAGES-1:0] BR_FLUSH  = low_mask(BR_STAGE);
  localparam logic [NUM_STAGES-1:0] MEM_STALL = low_mask(MEM_STAGE + 1);
  localparam logic [NUM_STAGES-1:0] MEM_BUB   = NUM_STAGES'(1) << (MEM_STAGE + 1);

  localparam int unsigned RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RESET_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = '1;

  localparam logic [1:0] FC_MEM_ERR = 2'd1;
  localparam logic [1:0] FC_TIMEOUT = 2'd2;

  typedef enum logic [1:0] {
    S_RESET_SEQ,
    S_RUN,
    S_MEM_WAIT,
    S_FAULT
  } state_t;

  state_t            state_q, state_d;
  logic [RST_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              fault_q, fault_d;
  logic [1:0]        fcode_q, fcode_d;

  logic code_ok, code_wait, code_err;
  assign code_ok   = (bus.i_mem_res_code == `MEM_CODE_OK);
  assign code_wait = (bus.i_mem_res_code == `MEM_CODE_WAIT);
  assign code_err  = !code_ok && !code_wait;  // any unknown code is an error

  // State register
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= S_RESET_SEQ;
      rst_cnt_q <= '0;
      wait_q    <= '0;
      fault_q   <= 1'b0;
      fcode_q   <= '0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      wait_q    <= wait_d;
      fault_q   <= fault_d;
      fcode_q   <= fcode_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    wait_d    = wait_q;
    fault_d   = fault_q;
    fcode_d   = fcode_q;
    unique case (state_q)
      S_RESET_SEQ: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d   = S_RUN;
          rst_cnt_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (bus.i_mem_req_en && code_wait) begin
          state_d = S_MEM_WAIT;
          wait_d  = '0;
        end else if (bus.i_mem_req_en && code_err) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
          fcode_d = FC_MEM_ERR;
        end
      end
      S_MEM_WAIT: begin
        if (code_ok) begin
          state_d = S_RUN;
        end else if (code_wait) begin
          // wait_q counts MEM_WAIT cycles already spent; this is the next one.
          if (wait_q >= WAIT_LAST) begin
            state_d = S_FAULT;
            fault_d = 1'b1;
            fcode_d = FC_TIMEOUT;
          end else if (wait_q != WAIT_MAX) begin
            wait_d = wait_q + 1'b1;
          end
        end else begin
          state_d = S_FAULT;
          fault_d = 1'b1;
          fcode_d = FC_MEM_ERR;
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_RESET_SEQ;
      end
    endcase
  end

  // Output logic: stall/clear act in the same cycle as the inputs
  logic [NUM_STAGES-1:0] stall_v, clr_v;
  logic                  busy_v;

  always_comb begin
    stall_v = '0;
    clr_v   = '0;
    busy_v  = 1'b0;
    if (clr) begin
      clr_v  = '1;
      busy_v = 1'b1;
    end else begin
      unique case (state_q)
        S_RESET_SEQ: begin
          clr_v  = '1;
          busy_v = 1'b1;
        end
        S_RUN: begin
          if (bus.i_mem_req_en && code_wait) begin
            stall_v = MEM_STALL;
            clr_v   = MEM_BUB;
          end else if (bus.i_mem_req_en && code_err) begin
            stall_v = '1;
          end else if (bus.i_branch) begin
            // The hazarding instruction is squashed, so no stall is needed.
            clr_v = BR_FLUSH;
          end else if (bus.i_mem_hazard) begin
            stall_v = ID_STALL;
            clr_v   = ID_BUB;
          end
        end
        S_MEM_WAIT: begin
          busy_v = 1'b1;
          // An OK response releases the stall so MEM_STAGE captures the data.
          if (!code_ok) begin
            stall_v = MEM_STALL;
            clr_v   = MEM_BUB;
          end
        end
        S_FAULT: begin
          stall_v = '1;
        end
        default: begin
          clr_v = '1;
        end
      endcase
    end
  end

  assign bus.o_stall      = stall_v;
  assign bus.o_clr        = clr_v;
  assign bus.o_busy       = busy_v;
  assign bus.o_fault      = fault_q;
  assign bus.o_fault_code = fcode_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl with the default parameters (5 stages).
`ifndef PIPE_CTRL_MEM_CODES
`define PIPE_CTRL_MEM_CODES
`define MEM_CODE_W    2
`define MEM_CODE_OK   2'd0
`define MEM_CODE_WAIT 2'd1
`define MEM_CODE_ERR  2'd2
`endif

module tb_pipe_ctrl;
  logic clk;
  logic clr;

  pipe_ctrl_if #(.NUM_STAGES(5)) bus();

  pipe_ctrl #(
    .NUM_STAGES  (5),
    .ID_STAGE    (1),
    .BR_STAGE    (2),
    .MEM_STAGE   (3),
    .RESET_CYCLES(4),
    .MEM_TIMEOUT (255)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic       hz;
    logic       br;
    logic       req;
    logic [1:0] code;
    logic [4:0] st;
    logic [4:0] cl;
    logic       flt;
    logic [1:0] fc;
    logic       busy;
  } vec_t;

  int errors = 0;
  int checks = 0;

  localparam logic [1:0] OK  = `MEM_CODE_OK;
  localparam logic [1:0] WT  = `MEM_CODE_WAIT;
  localparam logic [1:0] ER  = `MEM_CODE_ERR;
  localparam logic [1:0] BAD = 2'd3;

  function automatic vec_t mk(input string name, input logic rst, input logic hz, input logic br,
                              input logic req, input logic [1:0] code, input logic [4:0] st,
                              input logic [4:0] cl, input logic flt, input logic [1:0] fc,
                              input logic busy);
    vec_t v;
    v.name = name; v.rst = rst; v.hz = hz; v.br = br; v.req = req; v.code = code;
    v.st = st; v.cl = cl; v.flt = flt; v.fc = fc; v.busy = busy;
    return v;
  endfunction

  // Apply one cycle of inputs, compare outputs mid-cycle, then advance past the edge.
  // cf=0 leaves the fault flag/code out of the comparison.
  task automatic run(input vec_t v, input bit cf);
    logic [13:0] act, exp;
    clr                = v.rst;
    bus.i_mem_hazard   = v.hz;
    bus.i_branch       = v.br;
    bus.i_mem_req_en   = v.req;
    bus.i_mem_res_code = v.code;
    @(negedge clk);
    act = {bus.o_stall, bus.o_clr, bus.o_fault, bus.o_fault_code, bus.o_busy};
    exp = {v.st, v.cl, v.flt, v.fc, v.busy};
    if (!cf) begin
      act[3:1] = 3'b000;
      exp[3:1] = 3'b000;
    end
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: {stall,clr,fault,code,busy} got %b_%b_%b_%b_%b required %b_%b_%b_%b_%b",
               v.name, act[13:9], act[8:4], act[3], act[2:1], act[0],
               exp[13:9], exp[8:4], exp[3], exp[2:1], exp[0]);
    end
    @(posedge clk);
    #1;
  endtask

  // Pulse clr, then check the four clear cycles and the first idle RUN cycle.
  task automatic do_reset(input string tag);
    run(mk({tag, "_clr_hi"}, 1, 0, 0, 0, OK, 5'b00000, 5'b11111, 0, 2'd0, 1), 1'b0);
    for (int i = 0; i < 4; i++)
      run(mk({tag, "_rseq"}, 0, 0, 0, 0, OK, 5'b00000, 5'b11111, 0, 2'd0, 1), 1'b1);
    run(mk({tag, "_run"}, 0, 0, 0, 0, OK, 5'b00000, 5'b00000, 0, 2'd0, 0), 1'b1);
  endtask

  vec_t tbl[14];

  initial begin
    // Cycles applied back to back from RUN; state carries across rows.
    tbl[0]  = mk("idle",        0, 0, 0, 0, OK, 5'b00000, 5'b00000, 0, 2'd0, 0);
    tbl[1]  = mk("hazard",      0, 1, 0, 0, OK, 5'b00011, 5'b00100, 0, 2'd0, 0);
    tbl[2]  = mk("after_haz",   0, 0, 0, 0, OK, 5'b00000, 5'b00000, 0, 2'd0, 0);
    tbl[3]  = mk("br_and_haz",  0, 1, 1, 0, OK, 5'b00000, 5'b00011, 0, 2'd0, 0);
    tbl[4]  = mk("branch",      0, 0, 1, 0, OK, 5'b00000, 5'b00011, 0, 2'd0, 0);
    tbl[5]  = mk("req_ok",      0, 0, 0, 1, OK, 5'b00000, 5'b00000, 0, 2'd0, 0);
    tbl[6]  = mk("wait_no_req", 0, 0, 0, 0, WT, 5'b00000, 5'b00000, 0, 2'd0, 0);
    tbl[7]  = mk("wait_enter",  0, 1, 1, 1, WT, 5'b01111, 5'b10000, 0, 2'd0, 0);
    tbl[8]  = mk("wait_br",     0, 0, 1, 1, WT, 5'b01111, 5'b10000, 0, 2'd0, 1);
    tbl[9]  = mk("wait_haz",    0, 1, 0, 1, WT, 5'b01111, 5'b10000, 0, 2'd0, 1);
    tbl[10] = mk("wait_3",      0, 0, 1, 1, WT, 5'b01111, 5'b10000, 0, 2'd0, 1);
    tbl[11] = mk("wait_ok",     0, 0, 1, 1, OK, 5'b00000, 5'b00000, 0, 2'd0, 1);
    tbl[12] = mk("br_released", 0, 0, 1, 0, OK, 5'b00000, 5'b00011, 0, 2'd0, 0);
    tbl[13] = mk("idle2",       0, 0, 0, 0, OK, 5'b00000, 5'b00000, 0, 2'd0, 0);

    // Reset: clr high for three cycles, then four clear cycles with clr low.
    for (int i = 0; i < 3; i++)
      run(mk("clr_hold", 1, 0, 0, 0, OK, 5'b00000, 5'b11111, 0, 2'd0, 1), 1'b1);
    for (int i = 0; i < 4; i++)
      run(mk("reset_seq", 0, 0, 0, 0, OK, 5'b00000, 5'b11111, 0, 2'd0, 1), 1'b1);

    for (int i = 0; i < 14; i++) run(tbl[i], 1'b1);

    // ERR in RUN: fault latched next cycle; branch and new requests have no effect.
    run(mk("err_run",     0, 0, 0, 1, ER, 5'b11111, 5'b00000, 0, 2'd0, 0), 1'b1);
    run(mk("fault_br",    0, 0, 1, 0, OK, 5'b11111, 5'b00000, 1, 2'd1, 0), 1'b1);
    run(mk("fault_req",   0, 1, 0, 1, WT, 5'b11111, 5'b00000, 1, 2'd1, 0), 1'b1);
    do_reset("rec_err");

    // Unknown response code is an error.
    run(mk("bad_code",    0, 0, 0, 1, BAD, 5'b11111, 5'b00000, 0, 2'd0, 0), 1'b1);
    run(mk("bad_fault",   0, 0, 0, 0, OK,  5'b11111, 5'b00000, 1, 2'd1, 0), 1'b1);
    do_reset("rec_bad");

    // ERR while waiting.
    run(mk("w_enter",     0, 0, 0, 1, WT, 5'b01111, 5'b10000, 0, 2'd0, 0), 1'b1);
    run(mk("w_err",       0, 0, 0, 1, ER, 5'b01111, 5'b10000, 0, 2'd0, 1), 1'b1);
    run(mk("w_err_fault", 0, 0, 1, 0, OK, 5'b11111, 5'b00000, 1, 2'd1, 0), 1'b1);
    do_reset("rec_werr");

    // clr in the middle of a wait.
    run(mk("m_enter",     0, 0, 0, 1, WT, 5'b01111, 5'b10000, 0, 2'd0, 0), 1'b1);
    run(mk("m_wait",      0, 0, 0, 1, WT, 5'b01111, 5'b10000, 0, 2'd0, 1), 1'b1);
    do_reset("rec_mid");

    // Timeout: 255 MEM_WAIT cycles of WAIT, fault code 2 afterwards.
    run(mk("to_enter",    0, 0, 0, 1, WT, 5'b01111, 5'b10000, 0, 2'd0, 0), 1'b1);
    for (int i = 1; i <= 255; i++)
      run(mk($sformatf("to_wait_%0d", i), 0, 0, 0, 1, WT, 5'b01111, 5'b10000, 0, 2'd0, 1), 1'b1);
    run(mk("to_fault",    0, 0, 0, 1, WT, 5'b11111, 5'b00000, 1, 2'd2, 0), 1'b1);
    run(mk("to_fault_br", 0, 0, 1, 0, OK, 5'b11111, 5'b00000, 1, 2'd2, 0), 1'b1);
    do_reset("rec_to");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
